alu_result_bcd: RTL and testbench

- Sequential consumer of the miniALU 20-bit result bus.
- Converts a two's-complement or unsigned binary result into a sign flag plus packed BCD digits, using iterative double-dabble (shift-add-3).
- Sits between miniALU and the seven-segment display driver.
- Start/done handshake with a busy indication, so the display path holds a stable value while a conversion runs.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_result_bcd_if.sv | 25 ++
 rtl/bcd_digit_adj.sv | 10 +
 rtl/alu_result_bcd.sv | 101 ++++++++++
 tb/tb_alu_result_bcd.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared miniALU types and sizes.
// Also carries the result-to-BCD converter state encoding.
package alu_pkg;

  localparam int RESULT_W   = 20;
  localparam int BCD_DIGITS = 7;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    SHL = 2'b10,
    SHR = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/alu_result_bcd_if.sv
// Start/done bundle between miniALU result bus and BCD converter.
// master drives start/value, slave returns status and digits.
interface alu_result_bcd_if #(
  parameter int WIDTH  = 20,
  parameter int DIGITS = 7
);

  logic                  start;
  logic [WIDTH-1:0]      value;
  logic                  busy;
  logic                  done;
  logic                  neg;
  logic [DIGITS*4-1:0]   bcd;

  modport master (
    output start, value,
    input  busy, done, neg, bcd
  );

  modport slave (
    input  start, value,
    output busy, done, neg, bcd
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction.
// Adds 3 to a BCD digit of 5 or more before the shift.
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/alu_result_bcd.sv
// Iterative binary-to-BCD converter for the miniALU result.
// One magnitude bit per clock; sign split off up front.
module alu_result_bcd
  import alu_pkg::*;
#(
  parameter int WIDTH  = RESULT_W,
  parameter int DIGITS = BCD_DIGITS,
  parameter bit SIGNED = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  alu_result_bcd_if.slave io
);

  localparam int SW = DIGITS * 4;
  localparam int CW = $clog2(WIDTH + 1);

  state_t          state_q, state_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [SW-1:0]   scr_q, scr_d;
  logic [SW-1:0]   adj;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pneg_q, pneg_d;
  logic            neg_q, neg_d;
  logic [SW-1:0]   bcd_q, bcd_d;

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (scr_q[4*i +: 4]),
      .dout (adj[4*i +: 4])
    );
  end

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    pneg_d  = pneg_q;
    neg_d   = neg_q;
    bcd_d   = bcd_q;
    unique case (state_q)
      IDLE: begin
        if (io.start) begin
          if (SIGNED && io.value[WIDTH-1]) begin
            mag_d  = -io.value;
            pneg_d = 1'b1;
          end else begin
            mag_d  = io.value;
            pneg_d = 1'b0;
          end
          scr_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {scr_d, mag_d} = {adj, mag_q} << 1;
        cnt_d = cnt_q + CW'(1);
        // results land with the last shift so they are stable in DONE
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          bcd_d   = scr_d;
          neg_d   = pneg_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mag_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      pneg_q  <= 1'b0;
      neg_q   <= 1'b0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      pneg_q  <= pneg_d;
      neg_q   <= neg_d;
      bcd_q   <= bcd_d;
    end
  end

  assign io.busy = (state_q != IDLE);
  assign io.done = (state_q == DONE);
  assign io.neg  = neg_q;
  assign io.bcd  = bcd_q;

endmodule

// File: tb/tb_alu_result_bcd.sv
// Scoreboard bench for alu_result_bcd, signed and unsigned builds.
// Directed vectors; a monitor per DUT pops expectations on done.
module tb_alu_result_bcd;

  typedef struct {
    logic        neg;
    logic [27:0] bcd;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   busy_s = 0;
  int   busy_u = 0;
  exp_t q_s[$];
  exp_t q_u[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_result_bcd_if #(.WIDTH(20), .DIGITS(7)) bs ();
  alu_result_bcd_if #(.WIDTH(20), .DIGITS(7)) bu ();

  alu_result_bcd #(.WIDTH(20), .DIGITS(7), .SIGNED(1'b1)) dut_s (
    .clk (clk),
    .rst (rst),
    .io  (bs)
  );

  alu_result_bcd #(.WIDTH(20), .DIGITS(7), .SIGNED(1'b0)) dut_u (
    .clk (clk),
    .rst (rst),
    .io  (bu)
  );

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_s = 0;
    end else begin
      if (bs.busy) busy_s++;
      if (bs.done) begin
        if (q_s.size() == 0) begin
          chk("s_unexpected_done", 32'(bs.bcd), 32'hFFFF_FFFF);
        end else begin
          e = q_s.pop_front();
          chk("s_neg", 32'(bs.neg), 32'(e.neg));
          chk("s_bcd", 32'(bs.bcd), 32'(e.bcd));
          chk("s_latency", 32'(cyc - e.acc), 32'd21);
          chk("s_busy_len", 32'(busy_s), 32'd21);
        end
      end
      if (!bs.busy) busy_s = 0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_u = 0;
    end else begin
      if (bu.busy) busy_u++;
      if (bu.done) begin
        if (q_u.size() == 0) begin
          chk("u_unexpected_done", 32'(bu.bcd), 32'hFFFF_FFFF);
        end else begin
          e = q_u.pop_front();
          chk("u_neg", 32'(bu.neg), 32'(e.neg));
          chk("u_bcd", 32'(bu.bcd), 32'(e.bcd));
          chk("u_latency", 32'(cyc - e.acc), 32'd21);
          chk("u_busy_len", 32'(busy_u), 32'd21);
        end
      end
      if (!bu.busy) busy_u = 0;
    end
  end

  task automatic conv(input bit uns, input logic [19:0] v,
                      input logic n, input logic [27:0] b);
    exp_t e;
    @(posedge clk);
    #1;
    e.neg = n;
    e.bcd = b;
    e.acc = cyc;
    if (uns) begin
      bu.start = 1'b1;
      bu.value = v;
      q_u.push_back(e);
    end else begin
      bs.start = 1'b1;
      bs.value = v;
      q_s.push_back(e);
    end
    @(posedge clk);
    #1;
    bs.start = 1'b0;
    bu.start = 1'b0;
    bs.value = 20'h5A5A5;
    bu.value = 20'h5A5A5;
    repeat (21) @(posedge clk);
  endtask

  initial begin
    exp_t e;
    int k;
    bs.start = 1'b0;
    bs.value = '0;
    bu.start = 1'b0;
    bu.value = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(bs.busy), 32'd0);
    chk("rst_done", 32'(bs.done), 32'd0);
    chk("rst_neg", 32'(bs.neg), 32'd0);
    chk("rst_bcd", 32'(bs.bcd), 32'd0);
    chk("rst_u_bcd", 32'(bu.bcd), 32'd0);

    conv(0, 20'd20, 1'b0, 28'h0000020);
    conv(0, 20'hFFFFF, 1'b1, 28'h0000001);
    conv(0, 20'd10240, 1'b0, 28'h0010240);
    conv(0, 20'h80000, 1'b1, 28'h0524288);
    conv(0, 20'h7FFFF, 1'b0, 28'h0524287);
    conv(0, 20'd0, 1'b0, 28'h0000000);
    conv(1, 20'hFFFFF, 1'b0, 28'h1048575);
    conv(1, 20'h80000, 1'b0, 28'h0524288);
    conv(1, 20'd0, 1'b0, 28'h0000000);

    // starts at cycles 5 and 21 must be dropped; cycle 22 is taken
    @(posedge clk);
    #1;
    k = cyc;
    bs.start = 1'b1;
    bs.value = 20'd5;
    e.neg = 1'b0;
    e.bcd = 28'h0000005;
    e.acc = k;
    q_s.push_back(e);
    @(posedge clk);
    #1;
    bs.start = 1'b0;
    bs.value = 20'd99;
    repeat (4) @(posedge clk);
    #1 bs.start = 1'b1;
    @(posedge clk);
    #1 bs.start = 1'b0;
    repeat (15) @(posedge clk);
    #1 bs.start = 1'b1;
    @(posedge clk);
    #1;
    e.bcd = 28'h0000099;
    e.acc = k + 22;
    q_s.push_back(e);
    @(posedge clk);
    #1 bs.start = 1'b0;
    repeat (21) @(posedge clk);

    conv(0, 20'h80000, 1'b1, 28'h0524288);

    // asynchronous reset in the middle of a conversion
    @(posedge clk);
    #1;
    bs.start = 1'b1;
    bs.value = 20'd123456;
    @(posedge clk);
    #1 bs.start = 1'b0;
    repeat (9) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(bs.busy), 32'd0);
    chk("arst_done", 32'(bs.done), 32'd0);
    chk("arst_neg", 32'(bs.neg), 32'd0);
    chk("arst_bcd", 32'(bs.bcd), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (30) @(posedge clk);

    conv(0, 20'd7, 1'b0, 28'h0000007);

    for (int i = 0; i < 100; i++) begin
      if (q_s.size() == 0 && q_u.size() == 0) break;
      @(posedge clk);
    end
    @(negedge clk);
    chk("s_queue_drained", 32'(q_s.size()), 32'd0);
    chk("u_queue_drained", 32'(q_u.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
